sync_mod_counter: RTL and testbench
===================================

Name: sync_mod_counter

Overview:
- Parametrised synchronous binary counter. Generalises the 4-bit load/count slice: configurable width, up/down direction, programmable modulus, synchronous clear, and cascade enables (enp/ent) with ripple carry.
- Adds registered wrap and overflow reporting.
- Used as the counting element in benchmark datapaths. Stages cascade by chaining rco into the next stage's ent.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- MODULUS_EN, 1, 1: wrap at mod_val; 0: mod_val ignored, terminal value is all-ones.
- RESET_VALUE, 0, value loaded into q on rst and clr.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear to RESET_VALUE.
- load  in  1  synchronous parallel load of din.
- din  in  WIDTH  load data.
- enp  in  1  count enable (parallel).
- ent  in  1  count enable (trickle); also gates rco.
- up  in  1  1: count up, 0: count down.
- mod_val  in  WIDTH  terminal count when MODULUS_EN=1; sampled every cycle.
- q  out  WIDTH  counter value (registered).
- rco  out  1  combinational ripple carry: ent & tc.
- tc  out  1  combinational terminal-count flag.
- wrap  out  1  registered one-cycle pulse, cycle after a wrap.
- ovf  out  1  sticky overflow flag (registered).
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset values: q=RESET_VALUE, wrap=0, ovf=0. rst overrides all other inputs in the same cycle.
- mod_max = MODULUS_EN ? mod_val : all-ones.
- tc:
  - up=1: tc = (q==mod_max).
  - up=0: tc = (q==0).
  - tc follows up and mod_val combinationally.
- Per-cycle update priority: rst > clr > load > count > hold.
  - clr: q<=RESET_VALUE; no wrap.
  - load: q<=din, loaded unmodified even if din > mod_max; no wrap.
  - count: happens when enp & ent.
  - hold: happens when enp=0 or ent=0.
- Count up:
  - q==mod_max -> q<=0, wrap event.
  - q==all-ones (only reachable when q>mod_max) -> q<=0, wrap event.
  - otherwise q<=q+1.
- Count down:
  - q==0 -> q<=mod_max, wrap event.
  - otherwise q<=q-1, including from q>mod_max.
- mod_val==0:
  - Up counting from 0 wraps every counted cycle (q stays 0, wrap pulses each cycle).
  - Down counting from 0 also stays at 0 and wraps each cycle.
- wrap <= wrap event of the current cycle, so it is high exactly one cycle after each wrapping edge. Continuous wrapping gives continuous wrap=1.
- ovf:
  - Set when a wrap event occurs.
  - Cleared by ovf_clr.
  - Simultaneous wrap event and ovf_clr: set wins (ovf=1).
  - clr and load do not affect ovf; rst clears it.
- Direction change takes effect on the counting edge where up is sampled. No pipeline, latency 1 cycle input-to-q.
- Cascading: with stage0.rco -> stage1.ent and a shared enp, the chain behaves as one counter of summed width. All stages must use the same up.
- mod_val change mid-count: the new value applies from the next edge. If q now exceeds mod_max, the out-of-range rules above apply. No error flag.

Decomposition:
- Package sync_mod_counter_pkg holds:
  - typedef count_dir_e {DIR_DOWN=0, DIR_UP=1};
  - localparam priority encoding constants for the update-select mux (SEL_RST, SEL_CLR, SEL_LOAD, SEL_COUNT, SEL_HOLD).
- One combinational sub-module, sync_mod_counter_next. Inputs q, up, mod_max. Outputs q_inc_or_dec, wrap_evt, tc.
- The top level holds registers, the priority mux, and ovf/wrap flops.

Test Plan:
- Reset/priority: rst=1 with load=1, din=9 -> next cycle q=0, wrap=0, ovf=0. Then clr=1, load=1, din=9 -> q stays 0 (clr beats load).
- Modulo up (WIDTH=4, mod_val=9, up=1, enp=ent=1, start 0):
  - q sequence 0..9,0.
  - tc=1 and rco=1 only while q=9.
  - wrap=1 in the cycle q first shows 0; ovf=1 thereafter.
- Down wrap: load din=2, up=0, mod_val=9, count -> q sequence 2,1,0,9,8. tc=1 at q=0. wrap pulses the cycle q=9 appears.
- Enables and rco:
  - enp=0, ent=1 at q=9 -> q holds 9, rco=1.
  - ent=0 -> q holds, rco=0 although tc=1.
- Out-of-range and cascade:
  - Load din=12, mod_val=9, up=1 -> q sequence 13,14,15,0 with wrap on 15->0.
  - Two 4-bit instances chained via rco/ent, MODULUS_EN=0 -> combined 0x0F->0x10 on one edge, 0xFF->0x00.
- ovf collision: hold ovf_clr=1 on the cycle of a wrap event -> ovf=1 next cycle. ovf_clr=1 alone on the following cycle -> ovf=0.

Source files
------------

// File: rtl/sync_mod_counter_pkg.sv
// Shared types and constants for sync_mod_counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: count direction enum and the encodings for the per-cycle
// update-select mux in the top level.
package sync_mod_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  // Update-select encodings, listed in priority order (highest first).
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_RST   = 3'd0;
  localparam logic [SEL_W-1:0] SEL_CLR   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_LOAD  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_COUNT = 3'd3;
  localparam logic [SEL_W-1:0] SEL_HOLD  = 3'd4;

endpackage

// File: rtl/sync_mod_counter_next.sv
// Next-count and terminal-count logic for sync_mod_counter (purely combinational).
// Latency: 0 cycles.
// Backpressure: none; the caller decides whether the computed value is used.
//
// Ports:
//   q            in   current counter value
//   up           in   1: count up, 0: count down
//   mod_max      in   effective terminal value (mod_val or all-ones)
//   q_inc_or_dec out  value q would take on a counting edge
//   wrap_evt     out  a counting edge from this q would wrap
//   tc           out  terminal-count flag for the current direction
module sync_mod_counter_next
  import sync_mod_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q_inc_or_dec,
  output logic             wrap_evt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  count_dir_e dir;
  assign dir = count_dir_e'(up);

  always_comb begin
    q_inc_or_dec = q;
    wrap_evt     = 1'b0;
    tc           = 1'b0;
    if (dir == DIR_UP) begin
      tc = (q == mod_max);
      // All-ones is only reachable above mod_max (after a load or a
      // mod_val change); wrapping there keeps the counter from going
      // past the register width silently.
      wrap_evt     = tc || (q == ALL_ONES);
      q_inc_or_dec = wrap_evt ? ZERO : (q + ONE);
    end else begin
      tc           = (q == ZERO);
      wrap_evt     = tc;
      // Values above mod_max simply decrement back into range.
      q_inc_or_dec = tc ? mod_max : (q - ONE);
    end
  end

endmodule

// File: rtl/sync_mod_counter.sv
// Parametrised up/down modulo counter with clear, load, cascade enables and wrap/overflow flags.
// Latency: 1 cycle from inputs to q/wrap/ovf; tc and rco are combinational from q, up, mod_val, ent.
// Backpressure: none; enp & ent gate counting, stages cascade via rco -> next ent.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   clr, load, din   synchronous clear to RESET_VALUE / parallel load
//   enp, ent         count enables (ent also gates rco)
//   up, mod_val      direction and terminal count (mod_val used when MODULUS_EN=1)
//   q, tc, rco       counter value, terminal-count flag, ripple carry
//   wrap, ovf        registered wrap pulse and sticky overflow; ovf_clr clears ovf
module sync_mod_counter
  import sync_mod_counter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               MODULUS_EN  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mod_max;
  logic [WIDTH-1:0] q_next_cnt;
  logic             wrap_evt;
  logic             tc_int;
  logic [SEL_W-1:0] sel;

  assign mod_max = (MODULUS_EN != 0) ? mod_val : {WIDTH{1'b1}};

  sync_mod_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q            (q_q),
    .up           (up),
    .mod_max      (mod_max),
    .q_inc_or_dec (q_next_cnt),
    .wrap_evt     (wrap_evt),
    .tc           (tc_int)
  );

  // Priority select: rst > clr > load > count > hold.
  always_comb begin
    sel = SEL_HOLD;
    if (rst)             sel = SEL_RST;
    else if (clr)        sel = SEL_CLR;
    else if (load)       sel = SEL_LOAD;
    else if (enp && ent) sel = SEL_COUNT;
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    case (sel)
      SEL_RST: begin
        q_d   = RESET_VALUE;
        ovf_d = 1'b0;
      end
      SEL_CLR:   q_d = RESET_VALUE;
      SEL_LOAD:  q_d = din;
      SEL_COUNT: begin
        q_d    = q_next_cnt;
        wrap_d = wrap_evt;
      end
      default:   q_d = q_q;
    endcase
    // Setting wins over a simultaneous ovf_clr so no wrap is ever lost.
    if (sel != SEL_RST) begin
      if (wrap_d)       ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VALUE;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_int;
  assign rco  = ent & tc_int;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sync_mod_counter.sv
module tb_sync_mod_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic         rst = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] din = '0, mod_val = 4'd9;
  logic         enp = 1'b0, ent = 1'b0, up = 1'b1, ovf_clr = 1'b0;
  logic [W-1:0] q;
  logic         rco, tc, wrap, ovf;

  sync_mod_counter #(.WIDTH(W), .MODULUS_EN(1), .RESET_VALUE(4'd0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din),
    .enp(enp), .ent(ent), .up(up), .mod_val(mod_val),
    .q(q), .rco(rco), .tc(tc), .wrap(wrap), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Cascade pair (MODULUS_EN=0)
  logic         k_rst = 1'b0, k_load = 1'b0, k_enp = 1'b0, k_up = 1'b1;
  logic [W-1:0] k_din0 = '0, k_din1 = '0;
  logic [W-1:0] k_q0, k_q1;
  logic         k_rco0, k_rco1, k_tc0, k_tc1, k_wrap0, k_wrap1, k_ovf0, k_ovf1;
  logic [W-1:0] k_modv = '0;

  sync_mod_counter #(.WIDTH(W), .MODULUS_EN(0), .RESET_VALUE(4'd0)) c0 (
    .clk(clk), .rst(k_rst), .clr(1'b0), .load(k_load), .din(k_din0),
    .enp(k_enp), .ent(1'b1), .up(k_up), .mod_val(k_modv),
    .q(k_q0), .rco(k_rco0), .tc(k_tc0), .wrap(k_wrap0), .ovf(k_ovf0), .ovf_clr(1'b0)
  );

  sync_mod_counter #(.WIDTH(W), .MODULUS_EN(0), .RESET_VALUE(4'd0)) c1 (
    .clk(clk), .rst(k_rst), .clr(1'b0), .load(k_load), .din(k_din1),
    .enp(k_enp), .ent(k_rco0), .up(k_up), .mod_val(k_modv),
    .q(k_q1), .rco(k_rco1), .tc(k_tc1), .wrap(k_wrap1), .ovf(k_ovf1), .ovf_clr(1'b0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Reference model: counter value, wrap pulse and overflow flag as integers.
  int m_q = 0, m_wrap = 0, m_ovf = 0;

  function automatic int m_modmax(input int mv);
    return mv;  // MODULUS_EN=1 for the main DUT
  endfunction

  function automatic int m_tc(input int qv, input int u, input int mv);
    if (u != 0) return (qv == m_modmax(mv)) ? 1 : 0;
    return (qv == 0) ? 1 : 0;
  endfunction

  task automatic model_tick();
    int mm, nq, nw, no;
    mm = m_modmax(int'(mod_val));
    nq = m_q; nw = 0; no = m_ovf;
    if (rst) begin
      nq = 0; no = 0;
    end else begin
      if (clr)            nq = 0;
      else if (load)      nq = int'(din);
      else if (enp && ent) begin
        if (up) begin
          if (m_q == mm || m_q == MAXV) begin nq = 0; nw = 1; end
          else nq = m_q + 1;
        end else begin
          if (m_q == 0) begin nq = mm; nw = 1; end
          else nq = m_q - 1;
        end
      end
      if (nw != 0)      no = 1;
      else if (ovf_clr) no = 0;
    end
    m_q = nq; m_wrap = nw; m_ovf = no;
  endtask

  // One clock: model computes from pre-edge inputs, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    model_tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, clr, load;
    logic [W-1:0] din;
    logic enp, ent, up;
    logic [W-1:0] mv;
    logic oc;
    logic [W-1:0] e_q;
    logic e_tc, e_rco, e_wrap, e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic c, input logic l, input int d,
                              input logic ep, input logic et, input logic u, input int mv,
                              input logic oc, input int eq, input logic etc,
                              input logic erco, input logic ew, input logic eo);
    vec_t v;
    v.rst = r; v.clr = c; v.load = l; v.din = W'(d);
    v.enp = ep; v.ent = et; v.up = u; v.mv = W'(mv); v.oc = oc;
    v.e_q = W'(eq); v.e_tc = etc; v.e_rco = erco; v.e_wrap = ew; v.e_ovf = eo;
    tbl.push_back(v);
  endfunction

  initial begin
    // rst beats load; clr beats load
    add(1,0,1,9, 1,1,1,9,0,  0,0,0,0,0);
    add(0,1,1,9, 1,1,1,9,0,  0,0,0,0,0);
    // modulo-10 up count
    for (int k = 1; k <= 9; k++)
      add(0,0,0,0, 1,1,1,9,0,  k,(k==9),(k==9),0,0);
    add(0,0,0,0, 0,1,1,9,0,  9,1,1,0,0);   // enp=0: hold, rco still 1
    add(0,0,0,0, 1,0,1,9,0,  9,1,0,0,0);   // ent=0: hold, rco 0
    add(0,0,0,0, 1,1,1,9,0,  0,0,0,1,1);   // 9 -> 0 wraps
    add(0,0,0,0, 1,1,1,9,0,  1,0,0,0,1);
    // down wrap
    add(0,0,1,2, 1,1,0,9,0,  2,0,0,0,1);   // load beats count
    add(0,0,0,0, 1,1,0,9,0,  1,0,0,0,1);
    add(0,0,0,0, 1,1,0,9,0,  0,1,1,0,1);
    add(0,0,0,0, 1,1,0,9,0,  9,0,0,1,1);
    add(0,0,0,0, 1,1,0,9,0,  8,0,0,0,1);
    add(0,0,0,0, 0,1,0,9,1,  8,0,0,0,0);   // ovf_clr alone
    // out-of-range up
    add(0,0,1,12,1,1,1,9,0, 12,0,0,0,0);
    add(0,0,0,0, 1,1,1,9,0, 13,0,0,0,0);
    add(0,0,0,0, 1,1,1,9,0, 14,0,0,0,0);
    add(0,0,0,0, 1,1,1,9,0, 15,0,0,0,0);
    add(0,0,0,0, 1,1,1,9,0,  0,0,0,1,1);
    add(0,0,0,0, 0,1,1,9,1,  0,0,0,0,0);
    // wrap and ovf_clr together: set wins
    add(0,0,1,9, 1,1,1,9,0,  9,1,1,0,0);
    add(0,0,0,0, 1,1,1,9,1,  0,0,0,1,1);
    add(0,0,0,0, 0,1,1,9,1,  0,0,0,0,0);
    // mod_val=0 wraps every counted cycle, both directions
    add(0,0,0,0, 1,1,1,0,0,  0,1,1,1,1);
    add(0,0,0,0, 1,1,1,0,0,  0,1,1,1,1);
    add(0,0,0,0, 1,1,0,0,0,  0,1,1,1,1);
    add(0,1,0,0, 1,1,1,0,0,  0,1,1,0,1);   // clr keeps ovf
    add(0,0,0,0, 0,1,1,9,1,  0,0,0,0,0);
    // out-of-range down decrements
    add(0,0,1,14,0,1,0,9,0, 14,0,0,0,0);
    add(0,0,0,0, 1,1,0,9,0, 13,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; clr = tbl[i].clr; load = tbl[i].load; din = tbl[i].din;
      enp = tbl[i].enp; ent = tbl[i].ent; up = tbl[i].up; mod_val = tbl[i].mv;
      ovf_clr = tbl[i].oc;
      step();
      chk("tbl_q",    i, 32'(q),    32'(tbl[i].e_q));
      chk("tbl_tc",   i, 32'(tc),   32'(tbl[i].e_tc));
      chk("tbl_rco",  i, 32'(rco),  32'(tbl[i].e_rco));
      chk("tbl_wrap", i, 32'(wrap), 32'(tbl[i].e_wrap));
      chk("tbl_ovf",  i, 32'(ovf),  32'(tbl[i].e_ovf));
    end

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      clr     = ($urandom_range(0, 39) == 0);
      load    = ($urandom_range(0, 9) == 0);
      din     = W'($urandom_range(0, MAXV));
      enp     = ($urandom_range(0, 4) != 0);
      ent     = ($urandom_range(0, 4) != 0);
      ovf_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 29) == 0) mod_val = W'($urandom_range(0, MAXV));
      step();
      chk("rnd_q",    i, 32'(q),    32'(m_q));
      chk("rnd_wrap", i, 32'(wrap), 32'(m_wrap));
      chk("rnd_ovf",  i, 32'(ovf),  32'(m_ovf));
      chk("rnd_tc",   i, 32'(tc),   32'(m_tc(m_q, int'(up), int'(mod_val))));
      chk("rnd_rco",  i, 32'(rco),  32'(ent & m_tc(m_q, int'(up), int'(mod_val))));
    end

    // Cascade: two 4-bit stages act as one 8-bit counter
    k_rst = 1'b1; k_enp = 1'b0; k_up = 1'b1;
    @(posedge clk); #1;
    chk("casc_rst", 0, 32'({k_q1, k_q0}), 32'h00);
    k_rst = 1'b0; k_load = 1'b1; k_din1 = 4'h0; k_din0 = 4'hF;
    @(posedge clk); #1;
    chk("casc_ld0f", 1, 32'({k_q1, k_q0}), 32'h0F);
    k_load = 1'b0; k_enp = 1'b1;
    @(posedge clk); #1;
    chk("casc_0f_10", 2, 32'({k_q1, k_q0}), 32'h10);
    k_up = 1'b0;
    @(posedge clk); #1;
    chk("casc_10_0f", 3, 32'({k_q1, k_q0}), 32'h0F);
    k_up = 1'b1; k_load = 1'b1; k_din1 = 4'hF; k_din0 = 4'hF;
    @(posedge clk); #1;
    chk("casc_ldff", 4, 32'({k_q1, k_q0}), 32'hFF);
    k_load = 1'b0;
    @(posedge clk); #1;
    chk("casc_ff_00", 5, 32'({k_q1, k_q0}), 32'h00);
    chk("casc_wrap1", 5, 32'(k_wrap1), 32'd1);
    k_up = 1'b0;
    @(posedge clk); #1;
    chk("casc_00_ff", 6, 32'({k_q1, k_q0}), 32'hFF);
    k_enp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
